// File: rtl/nn_param_loader.sv
// Streams a flat parameter file (W1, B1, W2, B2 in file order) into register banks.
// Optional NN_LOADER_CHECKSUM_EN adds a running modulo-2^WIDTH sum of accepted words.
module nn_param_loader #(
  parameter int IN_SIZE  = 2,
  parameter int HIDDEN1  = 64,
  parameter int OUT_SIZE = 3,
  parameter int WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    s_valid,
  input  logic signed [WIDTH-1:0] s_data,
  output logic                    s_ready,
  output logic signed [WIDTH-1:0] W1 [HIDDEN1][IN_SIZE],
  output logic signed [WIDTH-1:0] B1 [HIDDEN1],
  output logic signed [WIDTH-1:0] W2 [OUT_SIZE][HIDDEN1],
  output logic signed [WIDTH-1:0] B2 [OUT_SIZE],
  output logic                    busy,
  output logic                    load_done
`ifdef NN_LOADER_CHECKSUM_EN
  ,
  output logic        [WIDTH-1:0] checksum
`endif
);

  localparam int MaxAB  = (IN_SIZE > HIDDEN1) ? IN_SIZE : HIDDEN1;
  localparam int MaxDim = (MaxAB > OUT_SIZE) ? MaxAB : OUT_SIZE;
  localparam int CntW   = (MaxDim > 1) ? $clog2(MaxDim) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StLoadW1,
    StLoadB1,
    StLoadW2,
    StLoadB2,
    StDone
  } state_e;

  state_e            state_q, state_d, next_sec;
  logic [CntW-1:0]   row_q, row_d, col_q, col_d;
  logic [CntW-1:0]   last_row, last_col;
  logic              accept, enter_load;

  assign busy       = (state_q == StLoadW1) || (state_q == StLoadB1) ||
                      (state_q == StLoadW2) || (state_q == StLoadB2);
  assign s_ready    = busy;
  assign load_done  = (state_q == StDone);
  assign accept     = s_valid && s_ready;
  assign enter_load = start && ((state_q == StIdle) || (state_q == StDone));

  // Bias sections are walked with the column counter only; row stays at 0.
  always_comb begin
    last_row = '0;
    last_col = '0;
    next_sec = state_q;
    unique case (state_q)
      StLoadW1: begin
        last_row = CntW'(HIDDEN1 - 1);
        last_col = CntW'(IN_SIZE - 1);
        next_sec = StLoadB1;
      end
      StLoadB1: begin
        last_col = CntW'(HIDDEN1 - 1);
        next_sec = StLoadW2;
      end
      StLoadW2: begin
        last_row = CntW'(OUT_SIZE - 1);
        last_col = CntW'(HIDDEN1 - 1);
        next_sec = StLoadB2;
      end
      StLoadB2: begin
        last_col = CntW'(OUT_SIZE - 1);
        next_sec = StDone;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    if (enter_load) begin
      state_d = StLoadW1;
      row_d   = '0;
      col_d   = '0;
    end else if (accept) begin
      if (col_q == last_col) begin
        col_d = '0;
        if (row_q == last_row) begin
          row_d   = '0;
          state_d = next_sec;
        end else begin
          row_d = row_q + 1'b1;
        end
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < HIDDEN1; r++) begin
        B1[r] <= '0;
        for (int c = 0; c < IN_SIZE; c++) W1[r][c] <= '0;
      end
      for (int r = 0; r < OUT_SIZE; r++) begin
        B2[r] <= '0;
        for (int c = 0; c < HIDDEN1; c++) W2[r][c] <= '0;
      end
    end else if (accept) begin
      for (int r = 0; r < HIDDEN1; r++) begin
        if (state_q == StLoadB1 && col_q == CntW'(r)) B1[r] <= s_data;
        for (int c = 0; c < IN_SIZE; c++) begin
          if (state_q == StLoadW1 && row_q == CntW'(r) && col_q == CntW'(c)) W1[r][c] <= s_data;
        end
      end
      for (int r = 0; r < OUT_SIZE; r++) begin
        if (state_q == StLoadB2 && col_q == CntW'(r)) B2[r] <= s_data;
        for (int c = 0; c < HIDDEN1; c++) begin
          if (state_q == StLoadW2 && row_q == CntW'(r) && col_q == CntW'(c)) W2[r][c] <= s_data;
        end
      end
    end
  end

`ifdef NN_LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst || enter_load) begin
      checksum <= '0;
    end else if (accept) begin
      checksum <= checksum + s_data;
    end
  end
`endif

endmodule

// File: tb/tb_nn_param_loader.sv
// Randomized bench for nn_param_loader against a flat-file-index reference model.
module tb_nn_param_loader;

  localparam int I     = 2;
  localparam int H     = 64;
  localparam int O     = 3;
  localparam int TOTAL = H * I + H + O * H + O;

  logic clk = 1'b0;
  logic rst, start, s_valid, s_ready, busy, load_done;
  logic signed [15:0] s_data;
  logic signed [15:0] w1 [H][I];
  logic signed [15:0] b1 [H];
  logic signed [15:0] w2 [O][H];
  logic signed [15:0] b2 [O];
`ifdef NN_LOADER_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  nn_param_loader #(
    .IN_SIZE (I),
    .HIDDEN1 (H),
    .OUT_SIZE(O),
    .WIDTH   (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .s_valid  (s_valid),
    .s_data   (s_data),
    .s_ready  (s_ready),
    .W1       (w1),
    .B1       (b1),
    .W2       (w2),
    .B2       (b2),
    .busy     (busy),
    .load_done(load_done)
`ifdef NN_LOADER_CHECKSUM_EN
    ,
    .checksum (checksum)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: a load is just a count of accepted words into a flat file.
  logic signed [15:0] ew1 [H][I];
  logic signed [15:0] eb1 [H];
  logic signed [15:0] ew2 [O][H];
  logic signed [15:0] eb2 [O];
  logic        m_loading, m_done;
  int          m_count;
  logic [15:0] m_sum;
  int          busy_cycles;
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int r = 0; r < H; r++) begin
      eb1[r] = '0;
      for (int c = 0; c < I; c++) ew1[r][c] = '0;
    end
    for (int r = 0; r < O; r++) begin
      eb2[r] = '0;
      for (int c = 0; c < H; c++) ew2[r][c] = '0;
    end
    m_loading = 1'b0;
    m_done    = 1'b0;
    m_count   = 0;
    m_sum     = '0;
  endtask

  task automatic set_exp(input int k, input logic [15:0] d);
    int a;
    if (k < H * I) ew1[k / I][k % I] = d;
    else if (k < H * I + H) eb1[k - H * I] = d;
    else if (k < H * I + H + O * H) begin
      a = k - H * I - H;
      ew2[a / H][a % H] = d;
    end else eb2[k - H * I - H - O * H] = d;
  endtask

  task automatic cyc(input logic r, input logic st, input logic v, input logic [15:0] d);
    rst = r; start = st; s_valid = v; s_data = d;
    @(posedge clk);
    if (r) model_reset();
    else if (m_loading && v) begin
      set_exp(m_count, d);
      m_sum = m_sum + d;
      m_count++;
      if (m_count == TOTAL) begin
        m_loading = 1'b0;
        m_done    = 1'b1;
      end
    end else if (!m_loading && st) begin
      m_loading = 1'b1;
      m_done    = 1'b0;
      m_count   = 0;
      m_sum     = '0;
    end
    #1;
    check("busy", {31'b0, busy}, {31'b0, m_loading});
    check("s_ready", {31'b0, s_ready}, {31'b0, m_loading});
    check("load_done", {31'b0, load_done}, {31'b0, m_done});
`ifdef NN_LOADER_CHECKSUM_EN
    check("checksum", {16'b0, checksum}, {16'b0, m_sum});
`endif
    if (busy) busy_cycles++;
  endtask

  task automatic compare_all();
    for (int r = 0; r < H; r++) begin
      check($sformatf("B1[%0d]", r), b1[r], eb1[r]);
      for (int c = 0; c < I; c++) check($sformatf("W1[%0d][%0d]", r, c), w1[r][c], ew1[r][c]);
    end
    for (int r = 0; r < O; r++) begin
      check($sformatf("B2[%0d]", r), b2[r], eb2[r]);
      for (int c = 0; c < H; c++) check($sformatf("W2[%0d][%0d]", r, c), w2[r][c], ew2[r][c]);
    end
  endtask

  // vmode: 0 valid held, 1 toggling, 2 random gaps (+ stray start pulses).
  // dmode: 0 value k+1, 1 random, 2 constant 0x0100.
  task automatic stream(input int vmode, input int dmode, input int abort_at, input int pulse_at);
    int          guard;
    int          tog;
    logic        v, st;
    logic [15:0] d;
    guard = 0;
    tog   = 0;
    busy_cycles = 0;
    cyc(1'b0, 1'b1, 1'b0, 16'h0);
    while (m_loading && guard < 4000) begin
      guard++;
      if (abort_at >= 0 && m_count == abort_at) begin
        cyc(1'b1, 1'b0, 1'b1, 16'h1234);
        return;
      end
      if (vmode == 0) v = 1'b1;
      else if (vmode == 1) v = (tog == 0);
      else v = ($urandom_range(0, 9) < 7);
      tog = 1 - tog;
      if (dmode == 0) d = 16'(m_count + 1);
      else if (dmode == 1) d = 16'($urandom);
      else d = 16'h0100;
      st = (pulse_at >= 0 && m_count == pulse_at) || (vmode == 2 && $urandom_range(0, 49) == 0);
      cyc(1'b0, st, v, d);
    end
    check("load_completed", {31'b0, load_done}, 32'd1);
  endtask

  initial begin
    model_reset();
    cyc(1'b1, 1'b0, 1'b0, 16'h0);
    cyc(1'b1, 1'b1, 1'b1, 16'h5555);
    compare_all();

    // Stream ignored while idle.
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 16'h7FFF);
    compare_all();

    // Ramp with s_valid held high.
    stream(0, 0, -1, -1);
    check("busy_cycles_held", busy_cycles, 387);
    check("W1[0][0]_ramp", w1[0][0], 32'd1);
    check("W1[63][1]_ramp", w1[63][1], 32'd128);
    check("B1[0]_ramp", b1[0], 32'd129);
    check("W2[0][0]_ramp", w2[0][0], 32'd193);
    check("B2[2]_ramp", b2[2], 32'd387);
    compare_all();

    // Stream ignored while done.
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 16'h7FFF);
    compare_all();

    // Same ramp with s_valid toggling.
    stream(1, 0, -1, -1);
    check("busy_cycles_toggle", busy_cycles, 773);
    compare_all();

    // Abort after 100 words, then a full random-gap load.
    stream(0, 1, 100, -1);
    check("abort_done", {31'b0, load_done}, 32'd0);
    compare_all();
    stream(2, 1, -1, -1);
    compare_all();

    // Start pulsed mid-load is ignored.
    stream(0, 0, -1, 50);
    compare_all();

    // Random restarts: earlier values persist until overwritten.
    for (int n = 0; n < 3; n++) begin
      stream(2, 1, -1, -1);
      for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'($urandom), 16'($urandom));
      compare_all();
    end
    stream(0, 1, 40, -1);
    compare_all();

`ifdef NN_LOADER_CHECKSUM_EN
    stream(2, 2, -1, -1);
    check("checksum_0100", {16'b0, checksum}, 32'h8300);
    cyc(1'b0, 1'b0, 1'b1, 16'h7FFF);
    check("checksum_stable", {16'b0, checksum}, 32'h8300);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
